hv_am_search_ctrl: RTL and testbench

- Sequences the folded associative-memory (AM) search for one query hypervector.
- Walks every class hypervector fold by fold and XORs each query fold with the matching class fold.
- Popcounts each XOR result with an internal hv_binary_adder, accumulates a Hamming distance per class, and tracks the running minimum.
- Sits between the encoder output / AM storage and the classification result interface; returns the predicted class and its distance.

---
 rtl/hv_am_search_ctrl_if.sv | 55 +++++
 rtl/hv_am_search_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_hv_am_search_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/hv_am_search_ctrl_if.sv
// Bundle of query/AM storage read port, search handshake and result
// handshake for the folded associative-memory search controller.
// master: the surrounding system (query source, fold storage, result sink).
// slave : the search controller itself.

`ifndef DISTANCE_WIDTH
`define DISTANCE_WIDTH 11
`endif

interface hv_am_search_ctrl_if #(
    parameter int CLASS_WIDTH        = 3,
    parameter int AM_NUM_FOLDS_WIDTH = 4,
    parameter int AM_FOLD_WIDTH      = 200,
    parameter int DIST_W             = `DISTANCE_WIDTH
);
    logic                          query_valid;
    logic                          query_ready;
    logic                          mem_rd_en;
    logic [AM_NUM_FOLDS_WIDTH-1:0] fold_addr;
    logic [CLASS_WIDTH-1:0]        class_addr;
    logic [AM_FOLD_WIDTH-1:0]      query_fold;
    logic [AM_FOLD_WIDTH-1:0]      class_fold;
    logic                          dout_valid;
    logic                          dout_ready;
    logic [CLASS_WIDTH-1:0]        predicted_class;
    logic [DIST_W-1:0]             min_distance;

    modport master (
        output query_valid,
        input  query_ready,
        input  mem_rd_en,
        input  fold_addr,
        input  class_addr,
        output query_fold,
        output class_fold,
        input  dout_valid,
        output dout_ready,
        input  predicted_class,
        input  min_distance
    );

    modport slave (
        input  query_valid,
        output query_ready,
        output mem_rd_en,
        output fold_addr,
        output class_addr,
        input  query_fold,
        input  class_fold,
        output dout_valid,
        input  dout_ready,
        output predicted_class,
        output min_distance
    );
endinterface

// File: rtl/hv_am_search_ctrl.sv
// Folded associative-memory search controller.
// Walks all class hypervectors class-major / fold-minor, XORs each class
// fold with the matching query fold, popcounts it, accumulates a Hamming
// distance per class and keeps the running argmin.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | query_ready=1, waiting for query_valid
// RUN   | one fold read per cycle, NUM_CLASSES*AM_NUM_FOLDS cycles
// DRAIN | no read; consumes the fold returned for the final read
// DONE  | result valid, held until dout_ready

`ifndef DISTANCE_WIDTH
`define DISTANCE_WIDTH 11
`endif

module hv_binary_adder #(
    parameter int IN_WIDTH  = 200,
    parameter int OUT_WIDTH = `DISTANCE_WIDTH
) (
    input  logic [IN_WIDTH-1:0]  bits_i,
    output logic [OUT_WIDTH-1:0] count_o
);
    // Population count of the input word.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            count_o = count_o + OUT_WIDTH'(bits_i[i]);
        end
    end
endmodule

module hv_am_search_ctrl #(
    parameter int NUM_CLASSES        = 5,
    parameter int CLASS_WIDTH        = 3,
    parameter int AM_NUM_FOLDS       = 10,
    parameter int AM_NUM_FOLDS_WIDTH = 4,
    parameter int AM_FOLD_WIDTH      = 200
) (
    input  logic                clk,
    input  logic                rst,
    hv_am_search_ctrl_if.slave  bus
);
    localparam int DIST_W = `DISTANCE_WIDTH;
    localparam logic [CLASS_WIDTH-1:0]        LAST_CLASS = CLASS_WIDTH'(NUM_CLASSES - 1);
    localparam logic [AM_NUM_FOLDS_WIDTH-1:0] LAST_FOLD  = AM_NUM_FOLDS_WIDTH'(AM_NUM_FOLDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic                          query_ready_q, query_ready_d;
    logic                          mem_rd_en_q, mem_rd_en_d;
    logic [AM_NUM_FOLDS_WIDTH-1:0] fold_q, fold_d;
    logic [CLASS_WIDTH-1:0]        class_q, class_d;
    logic                          dout_valid_q, dout_valid_d;

    // Tag travelling alongside the one-cycle storage read latency.
    logic                          tag_vld_q;
    logic [AM_NUM_FOLDS_WIDTH-1:0] tag_fold_q;
    logic [CLASS_WIDTH-1:0]        tag_class_q;

    logic [DIST_W-1:0]             acc_q, acc_d;
    logic [DIST_W-1:0]             min_q, min_d;
    logic [CLASS_WIDTH-1:0]        pred_q, pred_d;

    logic [AM_FOLD_WIDTH-1:0]      xor_fold;
    logic [DIST_W-1:0]             fold_pop;
    logic [DIST_W-1:0]             acc_base;
    logic [DIST_W-1:0]             candidate;
    logic                          last_read;

    assign xor_fold = bus.query_fold ^ bus.class_fold;

    hv_binary_adder #(
        .IN_WIDTH  (AM_FOLD_WIDTH),
        .OUT_WIDTH (DIST_W)
    ) u_popcount (
        .bits_i  (xor_fold),
        .count_o (fold_pop)
    );

    assign last_read = (class_q == LAST_CLASS) && (fold_q == LAST_FOLD);

    // Sequencer next-state and registered control outputs.
    always_comb begin
        state_d       = state_q;
        query_ready_d = 1'b0;
        mem_rd_en_d   = 1'b0;
        fold_d        = fold_q;
        class_d       = class_q;
        dout_valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                fold_d  = '0;
                class_d = '0;
                if (bus.query_valid) begin
                    state_d     = S_RUN;
                    mem_rd_en_d = 1'b1;
                end else begin
                    query_ready_d = 1'b1;
                end
            end
            S_RUN: begin
                if (last_read) begin
                    state_d = S_DRAIN;
                    fold_d  = '0;
                    class_d = '0;
                end else begin
                    mem_rd_en_d = 1'b1;
                    if (fold_q == LAST_FOLD) begin
                        fold_d  = '0;
                        class_d = class_q + 1'b1;
                    end else begin
                        fold_d = fold_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                state_d      = S_DONE;
                dout_valid_d = 1'b1;
            end
            S_DONE: begin
                if (bus.dout_ready) begin
                    state_d       = S_IDLE;
                    query_ready_d = 1'b1;
                end else begin
                    dout_valid_d = 1'b1;
                end
            end
            default: begin
                state_d       = S_IDLE;
                query_ready_d = 1'b1;
            end
        endcase
    end

    // Distance accumulation and argmin tracking on the tagged return data.
    // Fold 0 reloads the accumulator so one class never leaks into the next;
    // with a single fold the load and the compare happen in the same cycle.
    always_comb begin
        acc_base  = (tag_fold_q == '0) ? '0 : acc_q;
        candidate = acc_base + fold_pop;
        acc_d     = acc_q;
        min_d     = min_q;
        pred_d    = pred_q;
        if (tag_vld_q) begin
            acc_d = candidate;
            if (tag_fold_q == LAST_FOLD) begin
                // Strict compare: a tie keeps the lower class index.
                if ((tag_class_q == '0) || (candidate < min_q)) begin
                    min_d  = candidate;
                    pred_d = tag_class_q;
                end
            end
        end
    end

    // State, control and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            query_ready_q <= 1'b1;
            mem_rd_en_q   <= 1'b0;
            fold_q        <= '0;
            class_q       <= '0;
            dout_valid_q  <= 1'b0;
            tag_vld_q     <= 1'b0;
            tag_fold_q    <= '0;
            tag_class_q   <= '0;
            acc_q         <= '0;
            min_q         <= '0;
            pred_q        <= '0;
        end else begin
            state_q       <= state_d;
            query_ready_q <= query_ready_d;
            mem_rd_en_q   <= mem_rd_en_d;
            fold_q        <= fold_d;
            class_q       <= class_d;
            dout_valid_q  <= dout_valid_d;
            tag_vld_q     <= mem_rd_en_q;
            tag_fold_q    <= fold_q;
            tag_class_q   <= class_q;
            acc_q         <= acc_d;
            min_q         <= min_d;
            pred_q        <= pred_d;
        end
    end

    assign bus.query_ready     = query_ready_q;
    assign bus.mem_rd_en       = mem_rd_en_q;
    assign bus.fold_addr       = fold_q;
    assign bus.class_addr      = class_q;
    assign bus.dout_valid      = dout_valid_q;
    assign bus.predicted_class = pred_q;
    assign bus.min_distance    = min_q;

endmodule

// File: tb/tb_hv_am_search_ctrl.sv
// Directed bench for hv_am_search_ctrl with a registered fold-storage model.

module tb_hv_am_search_ctrl;
    localparam int C  = 5;
    localparam int CW = 3;
    localparam int F  = 10;
    localparam int FW = 4;
    localparam int W  = 200;
    localparam int DW = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [W-1:0] qmem [F];
    logic [W-1:0] cmem [C][F];

    hv_am_search_ctrl_if #(
        .CLASS_WIDTH(CW), .AM_NUM_FOLDS_WIDTH(FW), .AM_FOLD_WIDTH(W), .DIST_W(DW)
    ) ifc ();

    hv_am_search_ctrl #(
        .NUM_CLASSES(C), .CLASS_WIDTH(CW), .AM_NUM_FOLDS(F),
        .AM_NUM_FOLDS_WIDTH(FW), .AM_FOLD_WIDTH(W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    // Fold storage: data returned one cycle after the read strobe.
    always @(posedge clk) begin
        if (ifc.mem_rd_en) begin
            ifc.query_fold <= qmem[ifc.fold_addr];
            ifc.class_fold <= cmem[ifc.class_addr][ifc.fold_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic qv, input logic cv);
        for (int f = 0; f < F; f++) begin
            qmem[f] = {W{qv}};
            for (int k = 0; k < C; k++) cmem[k][f] = {W{cv}};
        end
    endtask

    task automatic random_query_classes_equal();
        for (int f = 0; f < F; f++) begin
            for (int b = 0; b < W; b++) qmem[f][b] = 1'($urandom_range(0, 1));
            for (int k = 0; k < C; k++) cmem[k][f] = qmem[f];
        end
    endtask

    task automatic flip(input int k, input int g);
        cmem[k][g / W][g % W] = ~cmem[k][g / W][g % W];
    endtask

    // Handshake, optional query_valid pulse at RUN cycle pulse_at, wait for dout_valid.
    task automatic start_and_wait(input int pulse_at, output int lat);
        int cyc;
        @(negedge clk);
        ifc.query_valid = 1'b1;
        @(negedge clk);
        ifc.query_valid = 1'b0;
        cyc = 1;
        while (!ifc.dout_valid && cyc < 200) begin
            ifc.query_valid = (cyc == pulse_at);
            @(negedge clk);
            cyc++;
        end
        ifc.query_valid = 1'b0;
        lat = cyc;
    endtask

    task automatic check_result(input string tag, input int exp_cls, input int exp_dist, input int lat);
        check({tag, "_latency"}, 32'(lat), 32'(52));
        check({tag, "_class"}, 32'(ifc.predicted_class), 32'(exp_cls));
        check({tag, "_dist"}, 32'(ifc.min_distance), 32'(exp_dist));
    endtask

    task automatic release_result(input string tag);
        ifc.dout_ready = 1'b1;
        @(negedge clk);
        ifc.dout_ready = 1'b0;
        check({tag, "_rel_valid"}, 32'(ifc.dout_valid), 32'(0));
        check({tag, "_rel_ready"}, 32'(ifc.query_ready), 32'(1));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_qready"}, 32'(ifc.query_ready), 32'(1));
        check({tag, "_rden"}, 32'(ifc.mem_rd_en), 32'(0));
        check({tag, "_fold"}, 32'(ifc.fold_addr), 32'(0));
        check({tag, "_class_addr"}, 32'(ifc.class_addr), 32'(0));
        check({tag, "_dvalid"}, 32'(ifc.dout_valid), 32'(0));
        check({tag, "_pred"}, 32'(ifc.predicted_class), 32'(0));
        check({tag, "_mind"}, 32'(ifc.min_distance), 32'(0));
    endtask

    initial begin
        int lat;
        int cyc;
        ifc.query_valid = 1'b0;
        ifc.dout_ready  = 1'b0;
        ifc.query_fold  = '0;
        ifc.class_fold  = '0;
        fill(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_values("reset");

        // Query equals class 2; others 1000 or 2000 bits away.
        random_query_classes_equal();
        for (int g = 0; g < F * W; g++) flip(0, g);
        for (int g = 0; g < 1000; g++) flip(1, g);
        for (int g = 1000; g < 2000; g++) flip(3, g);
        for (int g = 0; g < F * W; g++) if (((g / W) % 2) == 0) flip(4, g);
        start_and_wait(0, lat);
        check_result("exact", 2, 0, lat);
        release_result("exact");

        // Query all ones; class k has k*100 ones starting at bit 150 (crosses folds).
        fill(1'b1, 1'b0);
        for (int k = 1; k < C; k++)
            for (int g = 150; g < 150 + k * 100; g++) flip(k, g);
        start_and_wait(0, lat);
        check_result("ones", 4, 1600, lat);
        release_result("ones");

        // Classes 1 and 3 tie at 37; bits spaced 7 apart from bit 190.
        random_query_classes_equal();
        for (int i = 0; i < 50; i++) flip(0, 190 + i * 7);
        for (int i = 0; i < 37; i++) flip(1, 190 + i * 7);
        for (int i = 0; i < 100; i++) flip(2, 190 + i * 7);
        for (int i = 0; i < 37; i++) flip(3, 190 + i * 7);
        for (int i = 0; i < 38; i++) flip(4, 190 + i * 7);
        start_and_wait(0, lat);
        check_result("tie", 1, 37, lat);
        release_result("tie");

        // Maximum distance: every class all zero against an all-ones query.
        fill(1'b1, 1'b0);
        start_and_wait(0, lat);
        check_result("maxd", 0, 2000, lat);
        release_result("maxd");

        // Back-pressure with stray query_valid pulses in RUN and DONE (tie data).
        random_query_classes_equal();
        for (int i = 0; i < 50; i++) flip(0, 190 + i * 7);
        for (int i = 0; i < 37; i++) flip(1, 190 + i * 7);
        for (int i = 0; i < 100; i++) flip(2, 190 + i * 7);
        for (int i = 0; i < 37; i++) flip(3, 190 + i * 7);
        for (int i = 0; i < 38; i++) flip(4, 190 + i * 7);
        start_and_wait(10, lat);
        check_result("bp", 1, 37, lat);
        for (int i = 0; i < 20; i++) begin
            ifc.query_valid = (i == 5);
            @(negedge clk);
            check("bp_hold_valid", 32'(ifc.dout_valid), 32'(1));
            check("bp_hold_class", 32'(ifc.predicted_class), 32'(1));
            check("bp_hold_dist", 32'(ifc.min_distance), 32'(37));
            check("bp_hold_rden", 32'(ifc.mem_rd_en), 32'(0));
            check("bp_hold_qready", 32'(ifc.query_ready), 32'(0));
        end
        ifc.query_valid = 1'b0;
        release_result("bp");
        repeat (3) @(negedge clk);
        check("bp_idle_rden", 32'(ifc.mem_rd_en), 32'(0));
        check("bp_idle_qready", 32'(ifc.query_ready), 32'(1));

        // Reset at RUN cycle 23, then a fresh search on the ones pattern.
        fill(1'b0, 1'b1);
        @(negedge clk);
        ifc.query_valid = 1'b1;
        @(negedge clk);
        ifc.query_valid = 1'b0;
        cyc = 1;
        while (cyc < 23) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_in_run_rden", 32'(ifc.mem_rd_en), 32'(1));
        rst = 1'b1;
        ifc.query_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ifc.query_valid = 1'b0;
        check_reset_values("midrst");
        repeat (60) @(negedge clk);
        check("midrst_no_dvalid", 32'(ifc.dout_valid), 32'(0));
        check("midrst_no_rden", 32'(ifc.mem_rd_en), 32'(0));
        fill(1'b1, 1'b0);
        for (int k = 1; k < C; k++)
            for (int g = 150; g < 150 + k * 100; g++) flip(k, g);
        start_and_wait(0, lat);
        check_result("fresh", 4, 1600, lat);
        release_result("fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
